// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA sequencing controller.
//   rsa_state_e : FSM state encoding used by rsa_top
//   STG_*       : one-hot stage codes (bit 0 = PRD, bit 1 = NEW, bit 2 = UPD)
//   is_one_hot  : true only for one of the three legal stage codes
package rsa_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT_IN = 2'd1,
      ST_COMPUTE = 2'd2,
      ST_OUT     = 2'd3
   } rsa_state_e;

   localparam logic [2:0] STG_IDLE = 3'b000;
   localparam logic [2:0] STG_PRD  = 3'b001;
   localparam logic [2:0] STG_NEW  = 3'b010;
   localparam logic [2:0] STG_UPD  = 3'b100;

   function automatic logic is_one_hot(input logic [2:0] v);
      return (v == STG_PRD) || (v == STG_NEW) || (v == STG_UPD);
   endfunction

endpackage

// File: rtl/rsa_cycle_cnt.sv
// Compute-phase down-counter.
//   clk, sys_rst : clock and synchronous active-low reset
//   load         : load load_val (takes priority over dec)
//   load_val     : compute length in cycles (>= 1)
//   dec          : decrement while counting
//   done         : terminal count, high during the last counted cycle
module rsa_cycle_cnt
   import rsa_pkg::*;
#(
   parameter int CNT_W = 12
) (
   input  logic             clk,
   input  logic             sys_rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             done
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!sys_rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   // Loaded with N on entry, so a count of 1 marks the N-th compute cycle.
   assign done = (cnt == CNT_W'(1));

endmodule

// File: rtl/rsa_top.sv
// RSA stage sequencer: accepts a one-hot stage request, waits for the
// nonlinear unit's input, runs a stage-dependent compute interval and
// presents the result until the nonlinear unit takes it.
//   clk, sys_rst     : clock and synchronous active-low reset
//   landmark_num     : current landmark count (sampled on accept)
//   l_k              : landmark index of the observation (sampled on accept)
//   stage_val        : one-hot stage request, PRD=001 NEW=010 UPD=100
//   nonlinear_s_val  : nonlinear unit has data, per stage bit
//   nonlinear_s_rdy  : nonlinear unit accepts the result, per stage bit
//   stage_rdy        : 111 while idle, else 000
//   nonlinear_m_rdy  : ready for nonlinear data (accepted stage bit)
//   nonlinear_m_val  : result valid (accepted stage bit)
//
// state      | meaning
// -----------+----------------------------------------------
// ST_IDLE    | waiting for a one-hot stage request
// ST_WAIT_IN | waiting for nonlinear_s_val on the stage bit
// ST_COMPUTE | counting the stage compute length
// ST_OUT     | result valid until nonlinear_s_rdy on stage bit
module rsa_top
   import rsa_pkg::*;
#(
   parameter int X            = 4,
   parameter int Y            = 4,
   parameter int L            = 4,
   parameter int RSA_DW       = 16,
   parameter int TB_AW        = 11,
   parameter int CB_AW        = 17,
   parameter int MAX_LANDMARK = 500,
   parameter int ROW_LEN      = 10
) (
   input  logic               clk,
   input  logic               sys_rst,
   input  logic [ROW_LEN-1:0] landmark_num,
   input  logic [ROW_LEN-1:0] l_k,
   input  logic [2:0]         stage_val,
   input  logic [2:0]         nonlinear_s_val,
   input  logic [2:0]         nonlinear_s_rdy,
   output logic [2:0]         stage_rdy,
   output logic [2:0]         nonlinear_m_rdy,
   output logic [2:0]         nonlinear_m_val
);

   localparam int CNT_W = ROW_LEN + 2;

   rsa_state_e         state;
   logic [2:0]         stage_reg;
   logic [ROW_LEN-1:0] lm_reg;
   logic [ROW_LEN-1:0] lk_reg;
   logic [ROW_LEN-1:0] eff_lk;
   logic [CNT_W-1:0]   cmp_len;
   logic               in_xfer;
   logic               out_xfer;
   logic               cnt_done;

   // Array geometry and buffer widths belong to the datapath, not to this
   // sequencer; they are kept in the parameter list for a uniform interface.
   logic unused_cfg;
   assign unused_cfg = (X + Y + RSA_DW + TB_AW + CB_AW) == 0;

   assign in_xfer  = (state == ST_WAIT_IN) && |(nonlinear_s_val & stage_reg);
   assign out_xfer = (state == ST_OUT) && |(nonlinear_s_rdy & stage_reg);

   // An out-of-range landmark count or index falls back to the base length.
   always_comb begin
      eff_lk = lk_reg;
      if ((int'(lm_reg) > MAX_LANDMARK) || (lk_reg > lm_reg)) begin
         eff_lk = '0;
      end
      case (stage_reg)
         STG_NEW: cmp_len = CNT_W'(2 * L);
         STG_UPD: cmp_len = CNT_W'(L) + CNT_W'(eff_lk);
         default: cmp_len = CNT_W'(L);
      endcase
   end

   rsa_cycle_cnt #(.CNT_W(CNT_W)) u_cycle_cnt (
      .clk      (clk),
      .sys_rst  (sys_rst),
      .load     (in_xfer),
      .load_val (cmp_len),
      .dec      (state == ST_COMPUTE),
      .done     (cnt_done)
   );

   // Outputs are registered with the state so they change only with it.
   always_ff @(posedge clk) begin
      if (!sys_rst) begin
         state           <= ST_IDLE;
         stage_reg       <= STG_IDLE;
         lm_reg          <= '0;
         lk_reg          <= '0;
         stage_rdy       <= 3'b111;
         nonlinear_m_rdy <= 3'b000;
         nonlinear_m_val <= 3'b000;
      end else begin
         case (state)
            ST_IDLE: begin
               if (is_one_hot(stage_val)) begin
                  state           <= ST_WAIT_IN;
                  stage_reg       <= stage_val;
                  lm_reg          <= landmark_num;
                  lk_reg          <= l_k;
                  stage_rdy       <= 3'b000;
                  nonlinear_m_rdy <= stage_val;
               end
            end
            ST_WAIT_IN: begin
               if (in_xfer) begin
                  state           <= ST_COMPUTE;
                  nonlinear_m_rdy <= 3'b000;
               end
            end
            ST_COMPUTE: begin
               if (cnt_done) begin
                  state           <= ST_OUT;
                  nonlinear_m_val <= stage_reg;
               end
            end
            ST_OUT: begin
               if (out_xfer) begin
                  state           <= ST_IDLE;
                  stage_reg       <= STG_IDLE;
                  nonlinear_m_val <= 3'b000;
                  stage_rdy       <= 3'b111;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rsa_top.sv
module tb_rsa_top;

   logic       clk;
   logic       sys_rst;
   logic [9:0] landmark_num;
   logic [9:0] l_k;
   logic [2:0] stage_val;
   logic [2:0] nonlinear_s_val;
   logic [2:0] nonlinear_s_rdy;
   logic [2:0] stage_rdy;
   logic [2:0] nonlinear_m_rdy;
   logic [2:0] nonlinear_m_val;

   int n_total = 0;
   int n_pass  = 0;

   typedef struct {
      logic [2:0] stage;
      logic [9:0] lm;
      logic [9:0] lk;
      int         exp_n;
      int         hold;
   } vec_t;

   typedef struct {
      logic [2:0] stage;
      int         n;
   } exp_t;

   exp_t sb_q[$];
   vec_t vecs[9];

   rsa_top dut (
      .clk             (clk),
      .sys_rst         (sys_rst),
      .landmark_num    (landmark_num),
      .l_k             (l_k),
      .stage_val       (stage_val),
      .nonlinear_s_val (nonlinear_s_val),
      .nonlinear_s_rdy (nonlinear_s_rdy),
      .stage_rdy       (stage_rdy),
      .nonlinear_m_rdy (nonlinear_m_rdy),
      .nonlinear_m_val (nonlinear_m_val)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic run_txn(input vec_t v);
      int   n;
      exp_t e;
      @(negedge clk);
      chk("idle_stage_rdy", stage_rdy, 3'b111);
      stage_val    = v.stage;
      landmark_num = v.lm;
      l_k          = v.lk;
      @(negedge clk);
      chk("accept_stage_rdy", stage_rdy, 3'b000);
      chk("accept_m_rdy", nonlinear_m_rdy, v.stage);
      sb_q.push_back('{stage: v.stage, n: v.exp_n});
      // foreign stage request and foreign s_val bits must be ignored
      stage_val       = (v.stage == 3'b010) ? 3'b001 : 3'b010;
      nonlinear_s_val = ~v.stage;
      repeat (2) @(negedge clk);
      chk("wait_in_m_rdy_hold", nonlinear_m_rdy, v.stage);
      stage_val       = 3'b000;
      nonlinear_s_val = v.stage;
      @(negedge clk);
      nonlinear_s_val = 3'b000;
      chk("compute_m_rdy", nonlinear_m_rdy, 3'b000);
      n = 0;
      while (nonlinear_m_val == 3'b000 && n < 2000) begin
         n++;
         @(negedge clk);
      end
      e = sb_q.pop_front();
      chk("compute_len", n, e.n);
      chk("out_m_val", nonlinear_m_val, e.stage);
      for (int i = 0; i < v.hold; i++) begin
         @(negedge clk);
         chk("out_m_val_hold", nonlinear_m_val, e.stage);
      end
      nonlinear_s_rdy = v.stage;
      @(negedge clk);
      chk("done_m_val", nonlinear_m_val, 3'b000);
      chk("done_stage_rdy", stage_rdy, 3'b111);
      @(negedge clk);
      nonlinear_s_rdy = 3'b000;
      chk("no_second_xfer", stage_rdy, 3'b111);
   endtask

   initial begin
      int   m_rdy_e;
      int   m_val_e;
      int   srdy_e;
      int   pulses;
      sys_rst = 1'b0;
      landmark_num = '0;
      l_k = '0;
      stage_val = 3'b000;
      nonlinear_s_val = 3'b000;
      nonlinear_s_rdy = 3'b000;

      vecs[0] = '{stage: 3'b001, lm: 10'd0,    lk: 10'd0,    exp_n: 4,   hold: 0};
      vecs[1] = '{stage: 3'b010, lm: 10'd0,    lk: 10'd0,    exp_n: 8,   hold: 0};
      vecs[2] = '{stage: 3'b100, lm: 10'd5,    lk: 10'd5,    exp_n: 9,   hold: 20};
      vecs[3] = '{stage: 3'b100, lm: 10'd0,    lk: 10'd0,    exp_n: 4,   hold: 1};
      vecs[4] = '{stage: 3'b100, lm: 10'd3,    lk: 10'd5,    exp_n: 4,   hold: 0};
      vecs[5] = '{stage: 3'b100, lm: 10'd600,  lk: 10'd10,   exp_n: 4,   hold: 0};
      vecs[6] = '{stage: 3'b100, lm: 10'd500,  lk: 10'd500,  exp_n: 504, hold: 0};
      vecs[7] = '{stage: 3'b100, lm: 10'd1023, lk: 10'd1023, exp_n: 4,   hold: 0};
      vecs[8] = '{stage: 3'b001, lm: 10'd7,    lk: 10'd3,    exp_n: 4,   hold: 3};

      // reset held two cycles
      repeat (2) @(negedge clk);
      chk("rst_stage_rdy", stage_rdy, 3'b111);
      chk("rst_m_rdy", nonlinear_m_rdy, 3'b000);
      chk("rst_m_val", nonlinear_m_val, 3'b000);
      sys_rst = 1'b1;

      // non-one-hot requests are ignored
      foreach (vecs[0].stage[i]) begin end
      stage_val = 3'b011;
      repeat (2) @(negedge clk);
      chk("ignore_011", stage_rdy, 3'b111);
      stage_val = 3'b111;
      @(negedge clk);
      chk("ignore_111", stage_rdy, 3'b111);
      chk("ignore_111_m_rdy", nonlinear_m_rdy, 3'b000);
      stage_val = 3'b000;
      @(negedge clk);

      // exact cycle-by-cycle PRD sequence with held inputs
      for (int c = 0; c <= 13; c++) begin
         @(negedge clk);
         m_rdy_e = (c >= 1 && c <= 5) ? 1 : 0;
         m_val_e = (c == 10) ? 1 : 0;
         srdy_e  = (c == 0 || c >= 11) ? 7 : 0;
         chk($sformatf("prd_m_rdy_c%0d", c), nonlinear_m_rdy, m_rdy_e);
         chk($sformatf("prd_m_val_c%0d", c), nonlinear_m_val, m_val_e);
         chk($sformatf("prd_stage_rdy_c%0d", c), stage_rdy, srdy_e);
         stage_val       = (c <= 1) ? 3'b001 : 3'b000;
         nonlinear_s_val = (c >= 5 && c <= 6) ? 3'b001 : ((c >= 2 && c <= 3) ? 3'b010 : 3'b000);
         nonlinear_s_rdy = (c >= 10 && c <= 11) ? 3'b001 : 3'b000;
      end
      stage_val = 3'b000;
      nonlinear_s_val = 3'b000;
      nonlinear_s_rdy = 3'b000;

      foreach (vecs[i]) run_txn(vecs[i]);

      // reset during COMPUTE aborts with no output pulse
      @(negedge clk);
      stage_val = 3'b100;
      landmark_num = 10'd500;
      l_k = 10'd500;
      @(negedge clk);
      stage_val = 3'b000;
      nonlinear_s_val = 3'b100;
      @(negedge clk);
      nonlinear_s_val = 3'b000;
      repeat (5) @(negedge clk);
      sys_rst = 1'b0;
      @(negedge clk);
      sys_rst = 1'b1;
      chk("abort_stage_rdy", stage_rdy, 3'b111);
      chk("abort_m_rdy", nonlinear_m_rdy, 3'b000);
      chk("abort_m_val", nonlinear_m_val, 3'b000);
      pulses = 0;
      nonlinear_s_val = 3'b100;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (nonlinear_m_val != 3'b000 || stage_rdy != 3'b111) pulses++;
      end
      nonlinear_s_val = 3'b000;
      chk("abort_no_pulse", pulses, 0);

      // normal operation resumes after the abort
      run_txn(vecs[1]);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
